tmr_phase_gen: RTL
==================

# tmr_phase_gen

Parametrised triple-modular-redundant phase and bit-time generator: successor to the fixed three-channel clock logic. It keeps N redundant phase/bit counters and majority-votes them every cycle. Each channel's next state is computed from the voted state, so a single disturbed channel heals itself. It drives the voted one-hot phase, the bit-time index and a word strobe to the rest of the computer, and reports channel disagreement through sticky per-channel fault flags and a saturating error counter.

## Interface
- CHANNELS, 3: number of redundant channels; odd, ≥3.
- PHASES, 4: clock phases per bit time; ≥2.
- BITS, 14: bit times per word; ≥2.
- ERR_W, 8: error counter width.
- PW = clog2(PHASES) and BW = clog2(BITS) are derived widths.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- EN  in  CHANNELS  per-channel advance pulse (the per-channel oscillator tick).
- FORCE_SYNC  in  1  load every channel with the voted state.
- CLR_FAULT  in  1  clear FAULT and ERR_CNT.
- PHASE_O  out  PHASES  one-hot voted phase.
- BIT_O  out  BW  voted bit-time index.
- WORD_STB  out  1  one-cycle pulse after each word wrap.
- MISCMP  out  1  some channel disagreed with the vote in the previous cycle.
- FAULT  out  CHANNELS  sticky per-channel disagreement flags.
- ERR_CNT  out  ERR_W  saturating count of mismatch cycles.

## Operation
- Each channel i holds {ph_i (PW bits), bt_i (BW bits)}.
- Voted state V is the bitwise majority over all channels: a bit is 1 when more than CHANNELS/2 channels have it at 1. V is combinational from the registers.
- next(V) rules:
  - ph = V.ph+1, wrapping to 0 after PHASES-1.
  - bt increments only when V.ph = PHASES-1, wrapping to 0 after BITS-1.
- Channel update, in priority order:
  - FORCE_SYNC=1: channel i loads V (no advance).
  - EN[i]=1: channel i loads next(V).
  - Otherwise channel i holds its own value.
- Voted advance occurs when a majority of EN bits are 1 and FORCE_SYNC=0.
- Outputs:
  - PHASE_O = onehot(V.ph), combinational from registers.
  - BIT_O = V.bt, combinational from registers.
  - WORD_STB is registered: set on the edge where a voted advance takes V from (PHASES-1, BITS-1) to (0,0); low otherwise.
- Mismatch is evaluated on the current registers: mm_i = (channel i ≠ V); any_mm = OR of all mm_i.
- Registered each edge:
  - MISCMP <= any_mm.
  - FAULT[i] <= mm_i | (FAULT[i] & ~CLR_FAULT). Set wins over clear.
  - ERR_CNT <= CLR_FAULT ? (any_mm ? 1 : 0) : ERR_CNT + any_mm, saturating at all-ones.
- Out-of-range channel values (ph ≥ PHASES, bt ≥ BITS) vote normally; next() wraps any out-of-range voted ph or bt to 0.

## Timing
- Reset (RESET_N low, asynchronous): all channels {0,0}.
  - Outputs during reset: PHASE_O=1, BIT_O=0, WORD_STB=0, MISCMP=0, FAULT=0, ERR_CNT=0.
  - Release is synchronous to the next CLK edge.
  - Reset mid-word discards the partial word; no WORD_STB is emitted.
- Latency:
  - PHASE_O and BIT_O change in the same cycle as the advancing edge (zero cycles after the register update).
  - WORD_STB is high in the cycle where PHASE_O=1 and BIT_O=0 after a wrap.
  - MISCMP, FAULT and ERR_CNT lag the disagreement by one cycle.
- A single channel missing one EN pulse diverges by one step. It rejoins on its next EN, because next() is taken from V. MISCMP is high for the cycles in between, and V is unaffected throughout.
- A minority channel given a spurious EN advances to next(V) while the others hold. V is unchanged; the channel realigns on the next voted advance or on FORCE_SYNC.
- FORCE_SYNC together with EN: the sync load takes priority and V does not advance that cycle.
- A word is PHASES*BITS voted advances: 56 with the defaults.

## Test plan
- Reset check: assert RESET_N=0 mid-count -> outputs immediately PHASE_O=4'b0001, BIT_O=0, FAULT=0, ERR_CNT=0, WORD_STB=0.
- Free run: EN=3'b111 for 56 cycles from reset -> PHASE_O cycles 1,2,4,8. BIT_O steps 0..13. WORD_STB is a single pulse in the cycle after the 56th advance. MISCMP stays 0.
- Dropped tick: EN=3'b101 for one cycle at V=(2,5), then 3'b111 -> PHASE_O/BIT_O sequence identical to the free run. MISCMP=1 for exactly one cycle. FAULT=3'b010 and sticky. ERR_CNT=1.
- Minority hold: EN=3'b011 for 3 cycles -> V advances 3 steps. Channel 2 holds. ERR_CNT=3 after the lag cycle. Channel 2 realigns on the next 3'b111.
- Majority absent: EN=3'b001 -> V holds. Channel 0 sits one step ahead until FORCE_SYNC=1, then all channels equal V. MISCMP clears one cycle later.
- Saturation and clear, with ERR_W=2: hold a mismatch for 5 cycles -> ERR_CNT=3 (saturated). Then pulse CLR_FAULT with no mismatch -> FAULT=0 and ERR_CNT=0.

Source files
------------

// File: rtl/tmr_phase_gen_if.sv
// tmr_phase_gen_if: control inputs and voted outputs of the redundant phase generator.
//   EN         per-channel advance pulse
//   FORCE_SYNC load every channel with the voted state
//   CLR_FAULT  clear sticky fault flags and error counter
//   PHASE_O    one-hot voted phase
//   BIT_O      voted bit-time index
//   WORD_STB   one-cycle pulse after each word wrap
//   MISCMP     some channel disagreed with the vote last cycle
//   FAULT      sticky per-channel disagreement flags
//   ERR_CNT    saturating count of mismatch cycles
interface tmr_phase_gen_if #(
    parameter int CHANNELS = 3,
    parameter int PHASES   = 4,
    parameter int BITS     = 14,
    parameter int ERR_W    = 8
);
    localparam int BW = $clog2(BITS);
    logic [CHANNELS-1:0] EN;
    logic                FORCE_SYNC;
    logic                CLR_FAULT;
    logic [PHASES-1:0]   PHASE_O;
    logic [BW-1:0]       BIT_O;
    logic                WORD_STB;
    logic                MISCMP;
    logic [CHANNELS-1:0] FAULT;
    logic [ERR_W-1:0]    ERR_CNT;
    modport master (
        output EN, FORCE_SYNC, CLR_FAULT,
        input  PHASE_O, BIT_O, WORD_STB, MISCMP, FAULT, ERR_CNT
    );
    modport slave (
        input  EN, FORCE_SYNC, CLR_FAULT,
        output PHASE_O, BIT_O, WORD_STB, MISCMP, FAULT, ERR_CNT
    );
endinterface

// File: rtl/tmr_phase_gen.sv
// tmr_phase_gen: N-way redundant phase/bit-time counter with bitwise majority vote.
//   CLK      system clock, rising edge
//   RESET_N  asynchronous active-low reset
//   bus      slave side of tmr_phase_gen_if (EN, FORCE_SYNC, CLR_FAULT in;
//            PHASE_O, BIT_O, WORD_STB, MISCMP, FAULT, ERR_CNT out)
module tmr_phase_gen #(
    parameter int CHANNELS = 3,
    parameter int PHASES   = 4,
    parameter int BITS     = 14,
    parameter int ERR_W    = 8
) (
    input  logic           CLK,
    input  logic           RESET_N,
    tmr_phase_gen_if.slave bus
);
    localparam int PW = $clog2(PHASES);
    localparam int BW = $clog2(BITS);

    logic [PW-1:0]       ph [CHANNELS];
    logic [BW-1:0]       bt [CHANNELS];
    logic [PW-1:0]       v_ph, n_ph;
    logic [BW-1:0]       v_bt, n_bt;
    logic                ph_top, adv, wrap;
    logic [CHANNELS-1:0] mm;
    logic                word_stb, miscmp;
    logic [CHANNELS-1:0] fault;
    logic [ERR_W-1:0]    err_cnt;

    // Bitwise majority: each voted bit is set when more than half the channels set it.
    for (genvar b = 0; b < PW; b++) begin : g_vote_ph
        logic [CHANNELS-1:0] col;
        for (genvar c = 0; c < CHANNELS; c++) begin : g_col
            assign col[c] = ph[c][b];
        end
        assign v_ph[b] = $countones(col) > CHANNELS / 2;
    end
    for (genvar b = 0; b < BW; b++) begin : g_vote_bt
        logic [CHANNELS-1:0] col;
        for (genvar c = 0; c < CHANNELS; c++) begin : g_col
            assign col[c] = bt[c][b];
        end
        assign v_bt[b] = $countones(col) > CHANNELS / 2;
    end

    // Successor of the voted state; out-of-range fields collapse to zero.
    assign ph_top = int'(v_ph) == PHASES - 1;
    assign n_ph   = (int'(v_ph) >= PHASES - 1) ? '0 : v_ph + PW'(1);
    assign n_bt   = (int'(v_bt) >= BITS || (ph_top && int'(v_bt) == BITS - 1)) ? '0
                  : v_bt + BW'(ph_top);

    assign adv  = ($countones(bus.EN) > CHANNELS / 2) && !bus.FORCE_SYNC;
    assign wrap = adv && ph_top && int'(v_bt) == BITS - 1;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_mm
        assign mm[c] = (ph[c] != v_ph) || (bt[c] != v_bt);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int c = 0; c < CHANNELS; c++) begin
                ph[c] <= '0;
                bt[c] <= '0;
            end
            word_stb <= 1'b0;
            miscmp   <= 1'b0;
            fault    <= '0;
            err_cnt  <= '0;
        end else begin
            // Every channel advances from the vote, so a lagging channel heals on its next tick.
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.FORCE_SYNC) begin
                    ph[c] <= v_ph;
                    bt[c] <= v_bt;
                end else if (bus.EN[c]) begin
                    ph[c] <= n_ph;
                    bt[c] <= n_bt;
                end
            end
            word_stb <= wrap;
            miscmp   <= |mm;
            fault    <= mm | (fault & ~{CHANNELS{bus.CLR_FAULT}});
            err_cnt  <= bus.CLR_FAULT ? ERR_W'(|mm)
                      : (&err_cnt) ? err_cnt : err_cnt + ERR_W'(|mm);
        end
    end

    assign bus.PHASE_O  = PHASES'(1) << v_ph;
    assign bus.BIT_O    = v_bt;
    assign bus.WORD_STB = word_stb;
    assign bus.MISCMP   = miscmp;
    assign bus.FAULT    = fault;
    assign bus.ERR_CNT  = err_cnt;
endmodule
